// File: rtl/equalizer_mul_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier among NUM_REQ requesters.
// Requester IDs ride a tag pipeline matched to the multiplier latency; backpressure freezes both via ce.
module equalizer_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 19,
  parameter int B_W     = 7,
  parameter int P_W     = 26,
  parameter int MUL_LAT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   mul_ce,
  output logic [A_W-1:0]         mul_din0,
  output logic [B_W-1:0]         mul_din1,
  input  logic [P_W-1:0]         mul_dout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [P_W-1:0]         res_data,
  output logic                   busy
);

  logic [ID_W-1:0]    r_rr_ptr;
  logic [MUL_LAT-1:0] r_vld;
  logic [ID_W-1:0]    r_id [MUL_LAT];

  logic               w_grant_any;
  logic [ID_W-1:0]    w_grant_id;
  logic [ID_W-1:0]    w_cand;
  logic [ID_W-1:0]    w_ptr_nxt;

  assign res_valid = r_vld[MUL_LAT-1];
  assign res_id    = r_id[MUL_LAT-1];
  assign res_data  = mul_dout;
  assign busy      = |r_vld;
  // Only a valid result that cannot leave stalls; bubbles always drain.
  assign mul_ce    = ~(res_valid & ~res_ready);

  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_cand      = '0;
    if (mul_ce && !reset) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_cand = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
        if (!w_grant_any && req_valid[w_cand]) begin
          w_grant_any = 1'b1;
          w_grant_id  = w_cand;
        end
      end
    end
  end

  assign w_ptr_nxt = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    if (w_grant_any) begin
      req_ready[w_grant_id] = 1'b1;
      mul_din0 = req_a[w_grant_id*A_W +: A_W];
      mul_din1 = req_b[w_grant_id*B_W +: B_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld    <= '0;
      r_rr_ptr <= '0;
      for (int unsigned k = 0; k < MUL_LAT; k++) r_id[k] <= '0;
    end else if (mul_ce) begin
      r_vld[0] <= w_grant_any;
      r_id[0]  <= w_grant_id;
      for (int unsigned k = 1; k < MUL_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_id[k]  <= r_id[k-1];
      end
      if (w_grant_any) r_rr_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_equalizer_mul_arbiter.sv
// Scoreboard bench for equalizer_mul_arbiter with a ce-stalled multiplier model attached.
module tb_equalizer_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int A_W     = 19;
  localparam int B_W     = 7;
  localparam int P_W     = 26;
  localparam int MUL_LAT = 3;

  typedef struct packed {
    logic signed [A_W-1:0] a;
    logic signed [B_W-1:0] b;
  } op_t;

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic signed [P_W-1:0] p;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   mul_ce;
  logic [A_W-1:0]         mul_din0;
  logic [B_W-1:0]         mul_din1;
  logic [P_W-1:0]         mul_dout;
  logic                   res_valid;
  logic                   res_ready = 1'b1;
  logic [ID_W-1:0]        res_id;
  logic [P_W-1:0]         res_data;
  logic                   busy;

  op_t  rq [NUM_REQ][$];
  res_t exp_res[$];
  int   exp_grant[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  equalizer_mul_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
    .busy(busy)
  );

  // Pipelined multiplier without reset, frozen by ce.
  logic signed [P_W-1:0] m_pipe [MUL_LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      m_pipe[0] <= $signed(mul_din0) * $signed(mul_din1);
      for (int k = 1; k < MUL_LAT; k++) m_pipe[k] <= m_pipe[k-1];
    end
  end
  assign mul_dout = m_pipe[MUL_LAT-1];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int r, input longint a, input longint b);
    op_t o;
    o.a = a[A_W-1:0];
    o.b = b[B_W-1:0];
    rq[r].push_back(o);
  endtask

  task automatic eg(input int id);
    exp_grant.push_back(id);
  endtask

  task automatic er(input int id, input longint p);
    res_t e;
    e.id = id[ID_W-1:0];
    e.p  = p[P_W-1:0];
    exp_res.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Requester driver: pops accepted operands, then presents queue heads.
  initial begin
    logic [NUM_REQ-1:0] acc;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    forever begin
      @(negedge clk);
      acc = reset ? '0 : (req_valid & req_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (acc[i] && rq[i].size() > 0) rq[i].delete(0);
      #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_a[i*A_W +: A_W] = rq[i][0].a;
          req_b[i*B_W +: B_W] = rq[i][0].b;
        end else begin
          req_valid[i] = 1'b0;
          req_a[i*A_W +: A_W] = '0;
          req_b[i*B_W +: B_W] = '0;
        end
      end
    end
  end

  // Monitor: grants and results checked against the scoreboard queues.
  initial begin
    int   mg;
    res_t e;
    logic prev_stall;
    logic [ID_W-1:0] prev_id;
    logic [P_W-1:0]  prev_data;
    prev_stall = 1'b0;
    prev_id = '0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        chk("mul_ce_rule", mul_ce, !(res_valid && !res_ready));
        if (prev_stall) begin
          chk("hold_valid", res_valid, 1);
          chk("hold_id", res_id, prev_id);
          chk("hold_data", $signed(res_data), $signed(prev_data));
        end
        if (!mul_ce) chk("stall_no_grant", req_ready, 0);
        if (req_ready != '0) begin
          mg = 0;
          for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) mg = i;
          chk("grant_onehot", $onehot(req_ready), 1);
          chk("grant_to_valid", req_valid[mg], 1);
          if (exp_grant.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_unexpected: got grant %0d, expected no grant", mg);
          end else begin
            chk("grant_id", mg, exp_grant.pop_front());
          end
          chk("din0", $signed(mul_din0), $signed(req_a[mg*A_W +: A_W]));
          chk("din1", $signed(mul_din1), $signed(req_b[mg*B_W +: B_W]));
        end else begin
          chk("din0_idle", mul_din0, 0);
          chk("din1_idle", mul_din1, 0);
        end
        if (res_valid && res_ready) begin
          if (exp_res.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL res_unexpected: got id=%0d data=%0d, expected no result", res_id, $signed(res_data));
          end else begin
            e = exp_res.pop_front();
            chk("res_id", res_id, e.id);
            chk("res_data", $signed(res_data), e.p);
          end
        end
        prev_stall = res_valid && !res_ready;
        prev_id = res_id;
        prev_data = res_data;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  longint va [NUM_REQ][3] = '{'{1, -5, 12345}, '{2, -100, 7}, '{3, 1000, -1}, '{4, 250000, -7}};
  longint vb [NUM_REQ][3] = '{'{1, 7, -2}, '{3, -50, 9}, '{-4, 10, -1}, '{5, 2, 8}};
  longint vp [NUM_REQ][3] = '{'{1, -35, -24690}, '{6, 5000, 63}, '{-12, 10000, 1}, '{20, 500000, -56}};
  int     ord [4] = '{2, 3, 0, 1};

  initial begin
    step();
    neg();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    step();
    reset = 1'b0;
    neg();
    chk("idle_mul_ce", mul_ce, 1);
    chk("idle_res_valid", res_valid, 0);

    // Single op from req1.
    step();
    push(1, 1000, -3); eg(1); er(1, -3000);
    neg();
    chk("t1_busy_t0", busy, 0);
    chk("t1_ready", req_ready, 4'b0010);
    chk("t1_din0", $signed(mul_din0), 1000);
    chk("t1_din1", $signed(mul_din1), -3);
    for (int k = 1; k <= 4; k++) begin
      step();
      neg();
      chk("t1_busy", busy, k <= 3);
      chk("t1_res_valid", res_valid, k == 3);
    end

    // Full contention, pointer starts at 2.
    step();
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < NUM_REQ; r++) push(r, va[r][k], vb[r][k]);
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++) begin
        eg(ord[j]);
        er(ord[j], vp[ord[j]][k]);
      end
    for (int c = 0; c < 16; c++) begin
      neg();
      chk("t2_res_valid", res_valid, c >= 3 && c <= 14);
      chk("t2_grant_each_cycle", req_ready != '0, c <= 11);
      step();
    end

    // Backpressure with a full pipeline.
    push(0, 10, 10);  push(1, -20, 3); push(2, 30, -3); push(3, -40, -4);
    push(0, 5, -6);   push(1, 111, 2); push(2, -9, 9);  push(3, 262143, 1);
    eg(2); er(2, -90);  eg(3); er(3, 160);    eg(0); er(0, 100); eg(1); er(1, -60);
    eg(2); er(2, -81);  eg(3); er(3, 262143); eg(0); er(0, -30); eg(1); er(1, 222);
    repeat (3) step();
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      neg();
      chk("t3_mul_ce", mul_ce, 0);
      chk("t3_req_ready", req_ready, 0);
      chk("t3_res_id", res_id, 2);
      step();
    end
    res_ready = 1'b1;
    neg();
    chk("t3_next_grant", req_ready, 4'b0010);
    repeat (12) step();

    // Operand extremes.
    push(2, -262144, -64); eg(2); er(2, 16777216);
    push(2, 262143, 63);   eg(2); er(2, 16515009);
    push(2, -262144, 63);  eg(2); er(2, -16515072);
    repeat (8) step();

    // Reset with three ops in flight.
    push(3, 100, 2); push(0, -100, 2); push(1, 50, -1);
    eg(3); eg(0); eg(1);
    repeat (3) step();
    reset = 1'b1;
    push(0, -7, 3); push(2, 9, -8);
    eg(0); er(0, -21); eg(2); er(2, -72);
    neg();
    chk("t5_rst_ready", req_ready, 0);
    step();
    reset = 1'b0;
    neg();
    chk("t5_res_valid", res_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_first_grant", req_ready, 4'b0001);
    for (int c = 1; c <= 5; c++) begin
      step();
      neg();
      chk("t5_res_window", res_valid, c == 3 || c == 4);
    end

    // Fairness: req0 joins req1/req3 while the pointer sits at 2.
    step();
    for (int k = 1; k <= 4; k++) begin
      push(1, k, 2);
      push(3, 10 * k, -1);
    end
    eg(3); er(3, -10); eg(1); er(1, 2); eg(3); er(3, -20);
    eg(0); er(0, 49);  eg(1); er(1, 4); eg(3); er(3, -30);
    eg(1); er(1, 6);   eg(3); er(3, -40); eg(1); er(1, 8);
    repeat (2) step();
    push(0, -7, -7);
    neg();
    chk("t6_grant_t2", req_ready, 4'b1000);
    step();
    neg();
    chk("t6_req0_grant", req_ready, 4'b0001);
    repeat (12) step();

    chk("sb_res_empty", exp_res.size(), 0);
    chk("sb_grant_empty", exp_grant.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
